cpu_sequencer: RTL

Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB. It takes the combinational decode outputs of the control decoder plus memory and ALU status, and drives the per-stage enables. A single shared memory port serves both instruction and data accesses, using a req/ready handshake. MULT/DIV run as a fixed-length multi-cycle stall.

---
 rtl/cpu_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/(MULDIV|MEM)/WB over a
// single shared memory port and drives per-stage enables for the datapath.
module cpu_sequencer #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [5:0]       opcode,
  input  logic [5:0]       func,
  input  logic             reg_write,
  input  logic             mem_to_reg,
  input  logic             mem_write_en,
  input  logic             jump,
  input  logic             branch,
  input  logic             halted,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel_data,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             rf_write,
  output logic             muldiv_start,
  output logic             hilo_write,
  output logic             halt,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [2:0]       state
);

  localparam int unsigned MdW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  localparam logic [MdW-1:0] MdLoad = MdW'(MULDIV_CYCLES - 1);

  localparam logic [5:0] FuncMult = 6'b011000;
  localparam logic [5:0] FuncDiv  = 6'b011010;

  localparam logic [1:0] PcSeq    = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExec    = 3'd2,
    StMuldiv  = 3'd3,
    StMem     = 3'd4,
    StWb      = 3'd5,
    StHalt    = 3'd6,
    StIllegal = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [MdW-1:0]   md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_muldiv;

  assign is_muldiv = (opcode == 6'b000000) && ((func == FuncMult) || (func == FuncDiv));

  // State, mult/div countdown and retired-instruction counter registers
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= StFetch;
      md_cnt_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic and per-state output strobes
  always_comb begin
    state_d      = state_q;
    md_cnt_d     = md_cnt_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PcSeq;
    rf_write     = 1'b0;
    muldiv_start = 1'b0;
    hilo_write   = 1'b0;
    halt         = 1'b0;
    retire       = 1'b0;
    case (state_q)
      StFetch: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = halted ? StHalt : StExec;
      end
      StExec: begin
        // Branch is tested before the memory rule: branches arrive with mem_to_reg set
        if (is_muldiv) begin
          muldiv_start = 1'b1;
          md_cnt_d     = MdLoad;
          state_d      = StMuldiv;
        end else if (jump) begin
          pc_write = 1'b1;
          pc_src   = PcJump;
          retire   = 1'b1;
          state_d  = StFetch;
        end else if (branch) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PcBranch : PcSeq;
          retire   = 1'b1;
          state_d  = StFetch;
        end else if (mem_write_en || (reg_write && mem_to_reg)) begin
          state_d = StMem;
        end else if (reg_write) begin
          state_d = StWb;
        end else begin
          pc_write = 1'b1;
          retire   = 1'b1;
          state_d  = StFetch;
        end
      end
      StMuldiv: begin
        if (md_cnt_q != '0) begin
          md_cnt_d = md_cnt_q - 1'b1;
        end else begin
          hilo_write = 1'b1;
          pc_write   = 1'b1;
          retire     = 1'b1;
          state_d    = StFetch;
        end
      end
      StMem: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = mem_write_en;
        if (mem_ready) begin
          if (mem_write_en) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        rf_write = 1'b1;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = StFetch;
      end
      StHalt: begin
        halt = 1'b1;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    // Reset overrides every strobe in the same cycle, so no PC/RF write escapes
    if (!rst_b) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      ir_load      = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PcSeq;
      rf_write     = 1'b0;
      muldiv_start = 1'b0;
      hilo_write   = 1'b0;
      halt         = 1'b0;
      retire       = 1'b0;
    end
  end

  // Retired-instruction counter next value and debug/status outputs
  always_comb begin
    cnt_d      = retire ? cnt_q + CNT_W'(1) : cnt_q;
    retire_cnt = rst_b ? cnt_q : '0;
    state      = state_q;
  end

endmodule
